// File: rtl/sig_dist_1to4.sv
// 1-to-4 registered stream distributor: one valid/ready input steered by S or
// round-robin into four independent FIFOs, each draining on its own valid/ready.
module sig_dist_1to4 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [WIDTH-1:0]   D,
    input  logic [1:0]         S,
    input  logic               Mode,
    input  logic               In_vld,
    output logic               In_rdy,
    output logic [4*WIDTH-1:0] Y,
    output logic [3:0]         Y_vld,
    input  logic [3:0]         Y_rdy,
    output logic [1:0]         Rr_ptr,
    output logic               Busy
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0] tgt;
    logic [3:0] full;
    logic [3:0] empty;
    logic       accept;

    // Rst_n is active-high here: it names the reset net, not its polarity.
    always_comb begin
        tgt    = Mode ? Rr_ptr : S;
        In_rdy = !Rst_n && !full[tgt];
        accept = In_vld && In_rdy;
        Y_vld  = ~empty;
        Busy   = |Y_vld;
    end

    always_ff @(posedge Clk) begin
        if (Rst_n)
            Rr_ptr <= 2'd0;
        else if (accept && Mode)
            Rr_ptr <= Rr_ptr + 2'd1;
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW:0]      wr_ptr;
        logic [AW:0]      rd_ptr;
        logic [WIDTH-1:0] last_pop;
        logic             push;
        logic             pop;

        // Pointers carry one extra wrap bit so full and empty are distinguishable.
        always_comb begin
            empty[k] = (wr_ptr == rd_ptr);
            full[k]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
            push     = accept && (tgt == 2'(k));
            pop      = !empty[k] && Y_rdy[k];
            Y[k*WIDTH +: WIDTH] = empty[k] ? last_pop : mem[rd_ptr[AW-1:0]];
        end

        // NOTE: storage is not reset; the pointers alone define which entries
        // are live, so clearing the array would only cost reset fan-out.
        always_ff @(posedge Clk) begin
            if (push)
                mem[wr_ptr[AW-1:0]] <= D;
        end

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        always_ff @(posedge Clk) begin
            if (Rst_n) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                last_pop <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop) begin
                    rd_ptr   <= rd_ptr + (AW+1)'(1);
                    last_pop <= mem[rd_ptr[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_sig_dist_1to4.sv
// Directed bench for sig_dist_1to4: per-channel queue model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_sig_dist_1to4;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic               Clk = 1'b0;
    logic               Rst_n;
    logic [WIDTH-1:0]   D;
    logic [1:0]         S;
    logic               Mode;
    logic               In_vld;
    logic               In_rdy;
    logic [4*WIDTH-1:0] Y;
    logic [3:0]         Y_vld;
    logic [3:0]         Y_rdy;
    logic [1:0]         Rr_ptr;
    logic               Busy;

    int n_checks = 0;
    int n_fail   = 0;

    sig_dist_1to4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .D      (D),
        .S      (S),
        .Mode   (Mode),
        .In_vld (In_vld),
        .In_rdy (In_rdy),
        .Y      (Y),
        .Y_vld  (Y_vld),
        .Y_rdy  (Y_rdy),
        .Rr_ptr (Rr_ptr),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one queue per channel, a round-robin counter and the last popped beat.
    logic [WIDTH-1:0] mq [4][$];
    logic [WIDTH-1:0] m_last [4];
    int               m_rr    = 0;
    bit               m_valid = 0;

    always @(negedge Clk) begin
        int  t;
        bit  exp_rdy;
        bit  acc;
        logic [3:0] exp_vld;
        t       = Mode ? m_rr : int'(S);
        exp_rdy = !Rst_n && (mq[t].size() < DEPTH);
        if (m_valid) begin
            exp_vld = '0;
            for (int k = 0; k < 4; k++) begin
                exp_vld[k] = (mq[k].size() != 0);
                check($sformatf("y_ch%0d", k), 32'(Y[k*WIDTH +: WIDTH]),
                      32'(exp_vld[k] ? mq[k][0] : m_last[k]));
            end
            check("in_rdy", 32'(In_rdy), 32'(exp_rdy));
            check("y_vld", 32'(Y_vld), 32'(exp_vld));
            check("rr_ptr", 32'(Rr_ptr), 32'(m_rr));
            check("busy", 32'(Busy), 32'(exp_vld != 0));
        end
        // Advance the model to the state after the coming rising edge.
        if (Rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                m_last[k] = '0;
            end
            m_rr    = 0;
            m_valid = 1;
        end else if (m_valid) begin
            acc = In_vld && exp_rdy;
            for (int k = 0; k < 4; k++)
                if (Y_rdy[k] && mq[k].size() != 0)
                    m_last[k] = mq[k].pop_front();
            if (acc) begin
                mq[t].push_back(D);
                if (Mode)
                    m_rr = (m_rr + 1) % 4;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ych(input int k);
        return Y[k*WIDTH +: WIDTH];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n  = 1'b1;
        In_vld = 1'b1;
        D      = '0;
        S      = 2'd0;
        Mode   = 1'b0;
        Y_rdy  = 4'b0000;

        // Reset held for two edges with In_vld asserted.
        tick();
        check("rst_in_rdy", 32'(In_rdy), 32'd0);
        check("rst_y_vld", 32'(Y_vld), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_rr", 32'(Rr_ptr), 32'd0);
        check("rst_y", Y, 32'd0);
        tick();
        Rst_n  = 1'b0;
        In_vld = 1'b0;
        #1;
        check("post_rst_in_rdy", 32'(In_rdy), 32'd1);

        // Steered routing.
        for (int k = 0; k < 4; k++) begin
            D      = 8'hA0 + 8'(k);
            S      = 2'(k);
            In_vld = 1'b1;
            tick();
        end
        In_vld = 1'b0;
        check("steer_vld", 32'(Y_vld), 32'hF);
        for (int k = 0; k < 4; k++)
            check($sformatf("steer_y%0d", k), 32'(ych(k)), 32'(8'hA0 + 8'(k)));
        Y_rdy = 4'b1111;
        tick();
        Y_rdy = 4'b0000;
        check("steer_drained", 32'(Y_vld), 32'd0);
        check("steer_busy", 32'(Busy), 32'd0);

        // Backpressure on channel 2.
        S = 2'd2;
        In_vld = 1'b1;
        D = 8'h11; tick();
        D = 8'h22; tick();
        D = 8'h33; #1;
        check("bp_full_rdy", 32'(In_rdy), 32'd0);
        tick();
        check("bp_head", 32'(ych(2)), 32'h11);
        Y_rdy[2] = 1'b1; #1;
        check("bp_no_passthru", 32'(In_rdy), 32'd0);
        tick();
        Y_rdy[2] = 1'b0; #1;
        check("bp_rdy_after_pop", 32'(In_rdy), 32'd1);
        check("bp_head2", 32'(ych(2)), 32'h22);
        tick();
        In_vld   = 1'b0;
        Y_rdy[2] = 1'b1;
        tick();
        check("bp_head3", 32'(ych(2)), 32'h33);
        check("bp_vld3", 32'(Y_vld[2]), 32'd1);
        tick();
        check("bp_empty", 32'(Y_vld[2]), 32'd0);
        check("bp_hold", 32'(ych(2)), 32'h33);
        Y_rdy = 4'b0000;

        // Round-robin wrap with S randomised.
        Mode  = 1'b1;
        Y_rdy = 4'b1111;
        for (int i = 1; i <= 6; i++) begin
            D      = 8'(i);
            S      = 2'($urandom_range(0, 3));
            In_vld = 1'b1;
            tick();
            check($sformatf("rr_beat%0d_vld", i), 32'(Y_vld[(i-1)%4]), 32'd1);
            check($sformatf("rr_beat%0d_y", i), 32'(ych((i-1)%4)), 32'(i));
        end
        In_vld = 1'b0;
        check("rr_end_ptr", 32'(Rr_ptr), 32'd2);
        tick();

        // Strict round-robin stall: fill channel 1, then walk the pointer to 1.
        Mode  = 1'b0;
        S     = 2'd1;
        Y_rdy = 4'b1101;
        In_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            D = 8'h40 + 8'(i);
            tick();
        end
        Mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = 8'h50 + 8'(i);
            tick();
        end
        D = 8'h77;
        #1;
        check("stall_rr", 32'(Rr_ptr), 32'd1);
        check("stall_rdy", 32'(In_rdy), 32'd0);
        tick();
        tick();
        check("stall_rr_hold", 32'(Rr_ptr), 32'd1);
        check("stall_ch1_full", 32'(ych(1)), 32'h40);
        Y_rdy = 4'b1111;
        tick();
        check("stall_rdy_free", 32'(In_rdy), 32'd1);
        tick();
        In_vld = 1'b0;
        check("stall_rr_moved", 32'(Rr_ptr), 32'd2);
        for (int i = 0; i < 3; i++) tick();
        check("stall_drained", 32'(Busy), 32'd0);

        // Reset mid-stream with channels 0, 2, 3 holding data and Rr_ptr=3.
        Y_rdy  = 4'b0000;
        Mode   = 1'b0;
        In_vld = 1'b1;
        S = 2'd0; D = 8'h55; tick();
        S = 2'd3; D = 8'h66; tick();
        Mode = 1'b1; D = 8'h88; tick();
        check("mid_rr", 32'(Rr_ptr), 32'd3);
        check("mid_vld", 32'(Y_vld), 32'hD);
        Rst_n = 1'b1;
        Y_rdy = 4'b1111;
        D     = 8'h99;
        #1;
        check("mid_rst_rdy", 32'(In_rdy), 32'd0);
        tick();
        Rst_n = 1'b0;
        Y_rdy = 4'b0000;
        check("mid_rst_vld", 32'(Y_vld), 32'd0);
        check("mid_rst_rr", 32'(Rr_ptr), 32'd0);
        check("mid_rst_y", Y, 32'd0);
        D = 8'hAB;
        tick();
        In_vld = 1'b0;
        check("mid_next_vld", 32'(Y_vld), 32'h1);
        check("mid_next_y0", 32'(ych(0)), 32'hAB);
        Y_rdy = 4'b1111;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
